cp0_timer_irq: RTL

CP0_TIMER_IRQ -- requirements
Module: cp0_timer_irq

---
 rtl/cp0_timer_irq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cp0_timer_irq.sv
// MIPS-style CP0 register block: Count/Compare timer with sticky interrupt,
// Status/Cause/EPC exception bookkeeping and the pipeline interrupt request.
module cp0_timer_irq #(
    parameter int            DW       = 32,
    parameter int            N_INT    = 6,
    parameter int            PRESCALE = 1,
    parameter logic [DW-1:0] PRID     = DW'(32'h004C_0102)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [4:0]       waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [4:0]       raddr_i,
    output logic [DW-1:0]    rdata_o,
    input  logic [N_INT-1:0] int_i,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_code_i,
    input  logic [DW-1:0]    exc_pc_i,
    input  logic             exc_bd_i,
    input  logic             eret_i,
    output logic [DW-1:0]    count_o,
    output logic [DW-1:0]    compare_o,
    output logic [DW-1:0]    status_o,
    output logic [DW-1:0]    cause_o,
    output logic [DW-1:0]    epc_o,
    output logic             timer_int_o,
    output logic             int_req_o
);

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_PRID    = 5'd15;
    localparam logic [4:0] A_CONFIG  = 5'd16;

    localparam logic [DW-1:0] STATUS_MASK = DW'(32'hF000_FF03);
    localparam logic [DW-1:0] STATUS_RST  = DW'(32'h1000_0000);
    localparam logic [DW-1:0] CONFIG_VAL  = DW'(32'h0000_8000);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] compare_q, compare_d;
    logic [DW-1:0] status_q, status_d;
    logic [DW-1:0] epc_q, epc_d;
    logic          timer_q, timer_d;
    logic [5:0]    ip_q, ip_d;
    logic [1:0]    sw_q, sw_d;
    logic [4:0]    code_q, code_d;
    logic          bd_q, bd_d;
    logic [DW-1:0] cause_val;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign wr_count   = we_i && (waddr_i == A_COUNT);
    assign wr_compare = we_i && (waddr_i == A_COMPARE);
    assign wr_status  = we_i && (waddr_i == A_STATUS);
    assign wr_cause   = we_i && (waddr_i == A_CAUSE);
    assign wr_epc     = we_i && (waddr_i == A_EPC);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        status_d  = status_q;
        epc_d     = epc_q;
        timer_d   = timer_q;
        sw_d      = sw_q;
        code_d    = code_q;
        bd_d      = bd_q;
        ip_d      = '0;
        ip_d[N_INT-1:0] = int_i;

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = count_q + DW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (wr_count) begin
            count_d = wdata_i;
            presc_d = '0;
        end

        // Match is taken from the registered values, so the flag rises one cycle later.
        timer_d = timer_q | ((compare_q != '0) && (count_q == compare_q));
        if (wr_compare) begin
            compare_d = wdata_i;
            timer_d   = 1'b0;
        end

        if (wr_status) status_d = wdata_i & STATUS_MASK;
        if (wr_cause)  sw_d     = wdata_i[9:8];
        if (wr_epc)    epc_d    = wdata_i;

        // Later assignments win: exception over eret over register write.
        if (eret_i) status_d[1] = 1'b0;
        if (exc_valid_i) begin
            code_d      = exc_code_i;
            status_d[1] = 1'b1;
            epc_d       = epc_q;
            if (!status_q[1]) begin
                epc_d = exc_bd_i ? (exc_pc_i - DW'(4)) : exc_pc_i;
                bd_d  = exc_bd_i;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            status_q  <= STATUS_RST;
            epc_q     <= '0;
            timer_q   <= 1'b0;
            ip_q      <= '0;
            sw_q      <= '0;
            code_q    <= '0;
            bd_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
            ip_q      <= ip_d;
            sw_q      <= sw_d;
            code_q    <= code_d;
            bd_q      <= bd_d;
        end
    end

    always_comb begin
        cause_val        = '0;
        cause_val[31]    = bd_q;
        cause_val[30]    = timer_q;
        cause_val[15:10] = ip_q;
        cause_val[15]    = ip_q[5] | timer_q;
        cause_val[9:8]   = sw_q;
        cause_val[6:2]   = code_q;
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_val;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_q;
    assign int_req_o   = status_q[0] & ~status_q[1] & (|(cause_val[15:8] & status_q[15:8]));

    always_comb begin
        case (raddr_i)
            A_COUNT:   rdata_o = count_q;
            A_COMPARE: rdata_o = compare_q;
            A_STATUS:  rdata_o = status_q;
            A_CAUSE:   rdata_o = cause_val;
            A_EPC:     rdata_o = epc_q;
            A_PRID:    rdata_o = PRID;
            A_CONFIG:  rdata_o = CONFIG_VAL;
            default:   rdata_o = '0;
        endcase
        // A write in flight to the register being read is forwarded as it will be stored.
        if (we_i && (waddr_i == raddr_i)) begin
            case (raddr_i)
                A_COUNT, A_COMPARE, A_EPC: rdata_o = wdata_i;
                A_STATUS:                  rdata_o = wdata_i & STATUS_MASK;
                A_CAUSE:                   rdata_o = {cause_val[DW-1:10], wdata_i[9:8], cause_val[7:0]};
                default:                   ;
            endcase
        end
    end

endmodule
